// File: rtl/mips_defs_pkg.sv
// rtl/mips_defs_pkg.sv - shared definitions for the MIPS fetch pipeline
// Purpose: fetch FSM state encodings, bubble instruction encoding and
//          instruction field bit positions used by the IF stage and IF/ID register.
// Ports:   none (package).
package mips_defs_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_HOLD  = 2'd2,
      ST_DRAIN = 2'd3
   } fetch_state_t;

   // sll $0,$0,0
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   localparam int RS_MSB = 25;
   localparam int RS_LSB = 21;
   localparam int RT_MSB = 20;
   localparam int RT_LSB = 16;
   localparam int RD_MSB = 15;
   localparam int RD_LSB = 11;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with stall and flush
// Purpose: holds the fetched instruction and its PC+4 between IF and ID.
//          Priority: reset > flush (bubble) > stall (hold) > load / bubble.
// Ports:   clk, rst_n      clock, synchronous active-low reset
//          i_stall         hold all fields
//          i_flush         insert a bubble, overrides stall
//          i_load          an instruction is available this cycle
//          i_instr, i_pc4  instruction and its PC+4
//          o_instr, o_pc4, o_valid  registered IF/ID contents
module if_id_reg
   import mips_defs_pkg::*;
#(
   parameter logic [31:0] BUBBLE_INSTR = NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_stall,
   input  logic        i_flush,
   input  logic        i_load,
   input  logic [31:0] i_instr,
   input  logic [31:0] i_pc4,
   output logic [31:0] o_instr,
   output logic [31:0] o_pc4,
   output logic        o_valid
);

   logic [31:0] r_instr;
   logic [31:0] r_pc4;
   logic        r_valid;
   logic        w_take;

   assign w_take = i_load && !i_flush;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_instr <= BUBBLE_INSTR;
         r_pc4   <= '0;
         r_valid <= 1'b0;
      end else if (i_flush || !i_stall) begin
         // A flush always bubbles, even while the hazard unit stalls.
         r_instr <= w_take ? i_instr : BUBBLE_INSTR;
         r_pc4   <= w_take ? i_pc4   : '0;
         r_valid <= w_take;
      end
   end

   assign o_instr = r_instr;
   assign o_pc4   = r_pc4;
   assign o_valid = r_valid;

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS instruction-fetch stage with IF/ID register
// Purpose: owns the PC, issues req/ack fetches to instruction memory, buffers one
//          instruction across a stall, drains an in-flight fetch after a redirect.
// Ports:   clk, rst_n                    clock, synchronous active-low reset
//          stall                         hazard hold of PC and IF/ID
//          redirect_valid, redirect_pc   taken branch/jump target
//          imem_req, imem_addr           fetch request, held until imem_ack
//          imem_ack, imem_rdata          fetch response (zero-wait allowed)
//          IF_ID_Instr, IF_ID_PC4        registered instruction and PC+4
//          IF_ID_Rs, IF_ID_Rt, IF_ID_Rd  register fields of IF_ID_Instr
//          IF_ID_Valid                   1 = real instruction, 0 = bubble
module if_stage
   import mips_defs_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = mips_defs_pkg::NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] IF_ID_Instr,
   output logic [31:0] IF_ID_PC4,
   output logic [4:0]  IF_ID_Rs,
   output logic [4:0]  IF_ID_Rt,
   output logic [4:0]  IF_ID_Rd,
   output logic        IF_ID_Valid
);

   fetch_state_t r_state;
   logic [31:0]  r_pc;
   logic [31:0]  r_drain_addr;
   logic [31:0]  r_buf_instr;
   logic [31:0]  r_buf_pc4;

   logic [31:0]  w_pc4;
   logic         w_in_hold;
   logic         w_load;
   logic [31:0]  w_load_instr;
   logic [31:0]  w_load_pc4;

   assign w_pc4     = r_pc + 32'd4;
   assign w_in_hold = (r_state == ST_HOLD);

   assign imem_req  = (r_state == ST_REQ) || (r_state == ST_DRAIN);
   // While draining, r_pc already holds the redirect target; the bus keeps
   // showing the address of the fetch still in flight.
   assign imem_addr = (r_state == ST_DRAIN) ? r_drain_addr : r_pc;

   // In HOLD the IF/ID register only takes the buffer once stall drops,
   // which its own stall priority already guarantees.
   assign w_load       = ((r_state == ST_REQ) && imem_ack) || w_in_hold;
   assign w_load_instr = w_in_hold ? r_buf_instr : imem_rdata;
   assign w_load_pc4   = w_in_hold ? r_buf_pc4   : w_pc4;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_pc         <= RESET_PC;
         r_drain_addr <= RESET_PC;
         r_buf_instr  <= NOP_INSTR;
         r_buf_pc4    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_state <= ST_REQ;
               if (redirect_valid) r_pc <= redirect_pc;
            end
            ST_REQ: begin
               if (imem_ack) begin
                  r_pc <= redirect_valid ? redirect_pc : w_pc4;
                  if (!redirect_valid && stall) begin
                     r_state     <= ST_HOLD;
                     r_buf_instr <= imem_rdata;
                     r_buf_pc4   <= w_pc4;
                  end
               end else if (redirect_valid) begin
                  r_state      <= ST_DRAIN;
                  r_drain_addr <= r_pc;
                  r_pc         <= redirect_pc;
               end
            end
            ST_HOLD: begin
               if (redirect_valid) begin
                  r_state <= ST_REQ;
                  r_pc    <= redirect_pc;
               end else if (!stall) begin
                  r_state <= ST_REQ;
               end
            end
            ST_DRAIN: begin
               if (redirect_valid) r_pc <= redirect_pc;
               if (imem_ack) r_state <= ST_REQ;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   if_id_reg #(
      .BUBBLE_INSTR (NOP_INSTR)
   ) u_if_id_reg (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_stall (stall),
      .i_flush (redirect_valid),
      .i_load  (w_load),
      .i_instr (w_load_instr),
      .i_pc4   (w_load_pc4),
      .o_instr (IF_ID_Instr),
      .o_pc4   (IF_ID_PC4),
      .o_valid (IF_ID_Valid)
   );

   assign IF_ID_Rs = IF_ID_Instr[RS_MSB:RS_LSB];
   assign IF_ID_Rt = IF_ID_Instr[RT_MSB:RT_LSB];
   assign IF_ID_Rd = IF_ID_Instr[RD_MSB:RD_LSB];

endmodule
